queen_job_arbiter: RTL

QUEEN_JOB_ARBITER -- requirements
Module: queen_job_arbiter

---
 rtl/queen_job_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/queen_job_arbiter.sv
// Round-robin front end that serialises four requesters onto one shared
// eight-queen solver, with a per-job WAIT timeout and a saturating job counter.
module queen_job_arbiter #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    output logic [3:0]  ack,
    output logic [7:0]  rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic [15:0] job_count,
    output logic        slv_start,
    output logic        slv_abort,
    input  logic        slv_done,
    input  logic [7:0]  slv_result
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned JOBS_W = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [N_REQ-1:0]    r_ack;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_timeout;
    logic                r_busy;
    logic [JOBS_W-1:0]   r_job_count;
    logic                r_slv_start;

    logic [2*N_REQ-1:0]  w_req_dbl;
    logic [N_REQ-1:0]    w_req_rot;
    logic [ID_W-1:0]     w_offset;
    logic [ID_W-1:0]     w_winner;
    logic                w_timeout_hit;
    logic                w_grab;
    logic                w_done;
    logic                w_abort;

    // Rotate requests so the RR pointer sits at bit 0; lowest set bit wins.
    always_comb begin
        w_req_dbl = {req, req};
        w_req_rot = N_REQ'(w_req_dbl >> r_rr_ptr);
        w_offset  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_offset = ID_W'(unsigned'(i));
            end
        end
        w_winner = r_rr_ptr + w_offset;
    end

    assign w_timeout_hit = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (|req) w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT:   if (slv_done || w_timeout_hit) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode; done takes precedence over a coincident timeout.
    always_comb begin
        w_grab  = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE: w_grab = |req;
            S_WAIT: begin
                w_done  = slv_done;
                w_abort = !slv_done && w_timeout_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_wait_cnt    <= '0;
            r_ack         <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_job_count   <= '0;
            r_slv_start   <= 1'b0;
        end else begin
            r_slv_start <= w_grab;
            r_busy      <= (w_state_nxt != S_IDLE);

            if (w_grab) begin
                r_grant_id <= w_winner;
                r_rr_ptr   <= w_winner + ID_W'(1);
            end

            if (r_state == S_LAUNCH) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_WAIT) && !w_done && !w_abort) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end

            // Result and count are updated on entry to RESP so they are valid with ack.
            if (w_done) begin
                r_rsp_data    <= slv_result;
                r_rsp_timeout <= 1'b0;
                if (r_job_count != '1) begin
                    r_job_count <= r_job_count + JOBS_W'(1);
                end
            end else if (w_abort) begin
                r_rsp_data    <= '0;
                r_rsp_timeout <= 1'b1;
            end

            r_ack <= (w_done || w_abort) ? (N_REQ'(1) << r_grant_id) : '0;
        end
    end

    assign ack         = r_ack;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = r_busy;
    assign grant_id    = r_grant_id;
    assign job_count   = r_job_count;
    assign slv_start   = r_slv_start;
    // Abort must land in the deciding WAIT cycle, so it is decoded from the live done flag.
    assign slv_abort   = w_abort && !rst;

endmodule
